// File: rtl/vec_dot_engine.sv
// Sequential dot-product engine: streams VEC_LEN element pairs from two source
// memories over a shared address bus and emits one registered signed sum.
module vec_dot_engine #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int RESULT_WIDTH = 32,
   parameter int VEC_LEN      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   vec_base,
   output logic                    busy,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic [DATA_WIDTH-1:0]   b_data,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    result_valid
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   localparam int PW = 2 * DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VEC_LEN - 1);

   state_t                  r_state, w_next;
   logic                    r_rd_en, r_vld, r_result_valid;
   logic [ADDR_WIDTH-1:0]   r_rd_addr, r_cnt;
   logic [DATA_WIDTH-1:0]   r_a, r_b;
   logic [RESULT_WIDTH-1:0] r_acc, r_result;
   logic [PW-1:0]           w_prod;
   logic [RESULT_WIDTH-1:0] w_prod_rs, w_sum;
   logic                    w_last;

   // Operands are sign-extended to full width so an unsigned multiply yields the signed product.
   assign w_prod = {{DATA_WIDTH{r_a[DATA_WIDTH-1]}}, r_a} * {{DATA_WIDTH{r_b[DATA_WIDTH-1]}}, r_b};

   generate
      if (RESULT_WIDTH <= PW) begin : g_trunc
         assign w_prod_rs = w_prod[RESULT_WIDTH-1:0];
      end else begin : g_sext
         assign w_prod_rs = {{(RESULT_WIDTH-PW){w_prod[PW-1]}}, w_prod};
      end
   endgenerate

   assign w_sum  = r_acc + w_prod_rs;
   assign w_last = (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_READ;
         S_READ:  if (w_last) w_next = S_DRAIN;
         S_DRAIN: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Data returned for a strobe cycle is captured on the following edge and
   // summed one edge later, tracked by r_vld.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_en        <= 1'b0;
         r_rd_addr      <= '0;
         r_cnt          <= '0;
         r_vld          <= 1'b0;
         r_a            <= '0;
         r_b            <= '0;
         r_acc          <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_vld          <= r_rd_en;
         r_result_valid <= 1'b0;
         if (r_rd_en) begin
            r_a <= a_data;
            r_b <= b_data;
         end
         case (r_state)
            S_IDLE: if (start) begin
               r_rd_en   <= 1'b1;
               r_rd_addr <= vec_base;
               r_cnt     <= '0;
               r_acc     <= '0;
            end
            S_READ: begin
               if (w_last) begin
                  r_rd_en <= 1'b0;
               end else begin
                  r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                  r_cnt     <= r_cnt + ADDR_WIDTH'(1);
               end
               if (r_vld) r_acc <= w_sum;
            end
            S_DRAIN: begin
               r_result       <= r_vld ? w_sum : r_acc;
               r_result_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign rd_en        = r_rd_en;
   assign rd_addr      = r_rd_addr;
   assign result       = r_result;
   assign result_valid = r_result_valid;

endmodule

// File: tb/tb_vec_dot_engine.sv
// Directed bench for vec_dot_engine: combinational source memories, a simple
// downstream writer log, and a second VEC_LEN=1 instance for the short case.
module tb_vec_dot_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  vec_base = '0;
   logic        busy, rd_en, result_valid;
   logic [4:0]  rd_addr;
   logic [31:0] a_data, b_data, result;

   logic        start1 = 1'b0;
   logic [4:0]  vec_base1 = '0;
   logic        busy1, rd_en1, result_valid1;
   logic [4:0]  rd_addr1;
   logic [31:0] a_data1, b_data1, result1;

   logic [31:0] mem_a [0:31];
   logic [31:0] mem_b [0:31];
   logic [31:0] wr_mem [0:31];
   int          wr_ptr = 0;
   int          total = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   assign a_data  = mem_a[rd_addr];
   assign b_data  = mem_b[rd_addr];
   assign a_data1 = mem_a[rd_addr1];
   assign b_data1 = mem_b[rd_addr1];

   vec_dot_engine u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_base(vec_base),
      .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
      .a_data(a_data), .b_data(b_data),
      .result(result), .result_valid(result_valid)
   );

   vec_dot_engine #(.VEC_LEN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .vec_base(vec_base1),
      .busy(busy1), .rd_en(rd_en1), .rd_addr(rd_addr1),
      .a_data(a_data1), .b_data(b_data1),
      .result(result1), .result_valid(result_valid1)
   );

   // Downstream writer: stores each result on its valid pulse.
   always @(posedge clk) begin
      if (result_valid) begin
         wr_mem[wr_ptr[4:0]] <= result;
         wr_ptr <= wr_ptr + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Caller has start/vec_base driven for the sampling edge E0.
   task automatic run_op(input logic [4:0] base, input logic [31:0] exp,
                         input bit ign, input bit chain, input logic [4:0] nbase);
      logic [4:0] a;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a = base + 5'(k);
         chk("rd_en_hi", 32'(rd_en), 32'd1);
         chk("rd_addr", 32'(rd_addr), 32'(a));
         chk("busy_hi", 32'(busy), 32'd1);
         chk("rv_early", 32'(result_valid), 32'd0);
         if (ign && (k == 1 || k == 2)) begin
            start = 1'b1;
            vec_base = 5'd8;
         end else begin
            start = 1'b0;
         end
         step();
      end
      chk("rd_en_drop", 32'(rd_en), 32'd0);
      chk("busy_drain", 32'(busy), 32'd1);
      chk("rv_drain", 32'(result_valid), 32'd0);
      step();
      chk("rv_pulse", 32'(result_valid), 32'd1);
      chk("result", result, exp);
      chk("busy_done", 32'(busy), 32'd0);
      if (chain) begin
         start = 1'b1;
         vec_base = nbase;
      end
   endtask

   initial begin
      int p;
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
      mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
      mem_a[4] = 32'hFFFFFFFF; mem_a[5] = 32'hFFFFFFFE; mem_a[6] = 3; mem_a[7] = 0;
      mem_b[4] = 4; mem_b[5] = 5; mem_b[6] = 32'hFFFFFFFA; mem_b[7] = 9;
      for (int i = 8; i < 12; i++) begin
         mem_a[i] = 32'h7FFFFFFF;
         mem_b[i] = 32'h7FFFFFFF;
      end
      mem_a[30] = 2; mem_a[31] = 32'hFFFFFFFD;
      mem_b[30] = 10; mem_b[31] = 4;

      // Reset state
      step(); step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      rst_n = 1'b1;
      step();

      // VEC_LEN=1: single read at base 2 -> 3*7
      start1 = 1'b1; vec_base1 = 5'd2;
      step();
      start1 = 1'b0;
      chk("v1_rd_en", 32'(rd_en1), 32'd1);
      chk("v1_rd_addr", 32'(rd_addr1), 32'd2);
      step();
      chk("v1_rd_drop", 32'(rd_en1), 32'd0);
      chk("v1_rv_early", 32'(result_valid1), 32'd0);
      step();
      chk("v1_rv", 32'(result_valid1), 32'd1);
      chk("v1_result", result1, 32'd21);
      step();

      // Basic: [1,2,3,4].[5,6,7,8] = 70, then result holds
      start = 1'b1; vec_base = 5'd0;
      run_op(5'd0, 32'd70, 1'b0, 1'b0, 5'd0);
      step();
      chk("rv_one_cycle", 32'(result_valid), 32'd0);
      chk("result_hold", result, 32'd70);

      // Signed operands -> -32
      start = 1'b1; vec_base = 5'd4;
      run_op(5'd4, 32'hFFFFFFE0, 1'b0, 1'b0, 5'd0);
      step();

      // Overflow wraps modulo 2^32
      start = 1'b1; vec_base = 5'd8;
      run_op(5'd8, 32'h00000004, 1'b0, 1'b0, 5'd0);
      step();

      // Address wrap 30,31,0,1 -> 20-12+5+12
      start = 1'b1; vec_base = 5'd30;
      run_op(5'd30, 32'd25, 1'b0, 1'b0, 5'd0);
      step();

      // Starts while busy are dropped
      start = 1'b1; vec_base = 5'd0;
      run_op(5'd0, 32'd70, 1'b1, 1'b0, 5'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         chk("no_queued_rv", 32'(result_valid), 32'd0);
         chk("no_queued_busy", 32'(busy), 32'd0);
      end

      // Back-to-back into the writer
      p = wr_ptr;
      start = 1'b1; vec_base = 5'd0;
      run_op(5'd0, 32'd70, 1'b0, 1'b1, 5'd4);
      run_op(5'd4, 32'hFFFFFFE0, 1'b0, 1'b0, 5'd0);
      step();
      chk("wr_first", wr_mem[p[4:0]], 32'd70);
      chk("wr_second", wr_mem[5'(p + 1)], 32'hFFFFFFE0);
      chk("wr_count", 32'(wr_ptr), 32'(p + 2));

      // Reset during READ aborts; start on first released edge is honoured
      start = 1'b1; vec_base = 5'd0;
      step();
      start = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
      chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_rv", 32'(result_valid), 32'd0);
      rst_n = 1'b1;
      start = 1'b1; vec_base = 5'd4;
      run_op(5'd4, 32'hFFFFFFE0, 1'b0, 1'b0, 5'd0);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/vec_dot_engine.md
VEC_DOT_ENGINE -- requirements
Module: vec_dot_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, element width of vectors A and B.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, source memory address width.
REQ-003 SHALL have parameter RESULT_WIDTH, default 32, dot-product result width.
REQ-004 SHALL have parameter VEC_LEN, default 4, elements per dot product (1..2^ADDR_WIDTH).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  request one dot product; sampled only in IDLE.
REQ-008 SHALL have port vec_base  input  ADDR_WIDTH  first element address, latched with start.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port rd_en  output  1  registered read strobe to both source memories.
REQ-011 SHALL have port rd_addr  output  ADDR_WIDTH  registered read address, shared by A and B memories.
REQ-012 SHALL have port a_data  input  DATA_WIDTH  signed A element, valid one cycle after rd_en.
REQ-013 SHALL have port b_data  input  DATA_WIDTH  signed B element, valid one cycle after rd_en.
REQ-014 SHALL have port result  output  RESULT_WIDTH  registered dot product; feeds downstream writer data_in.
REQ-015 SHALL have port result_valid  output  1  one-cycle pulse; feeds downstream writer start_writing.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN.
REQ-017 IDLE: on start=1 at edge E0, SHALL latch vec_base, clear accumulator, set rd_en=1, rd_addr=vec_base, go READ.
REQ-018 READ: SHALL advance rd_addr by 1 per cycle, issuing exactly VEC_LEN consecutive reads at E0..E(VEC_LEN-1); rd_en SHALL drop at E(VEC_LEN), state goes DRAIN.
REQ-019 rd_addr SHALL wrap modulo 2^ADDR_WIDTH (base 30, ADDR_WIDTH 5 -> 30,31,0,1).
REQ-020 SHALL capture a_data/b_data at each edge following a read-strobe cycle (E1..E(VEC_LEN)) and accumulate the product; a one-stage delayed valid flag SHALL gate accumulation.
REQ-021 Product SHALL be signed 2*DATA_WIDTH bits; accumulator SHALL be RESULT_WIDTH bits, sign-extended/truncated, wrapping modulo 2^RESULT_WIDTH, no saturation.
REQ-022 DRAIN: at edge E(VEC_LEN+1) SHALL load result with final sum, assert result_valid for exactly one cycle, return IDLE.
REQ-023 Latency: result_valid high in cycle following E(VEC_LEN+1), i.e. VEC_LEN+1 cycles after start sampled.
REQ-024 result SHALL hold its value until the next completed dot product.
REQ-025 start while busy=1 SHALL be ignored, no queuing; vec_base ignored likewise.
REQ-026 start=1 in the cycle result_valid is high SHALL be accepted (state already IDLE), giving back-to-back operations with no gap cycle.
REQ-027 VEC_LEN=1 SHALL issue one read and produce result at E2.

Reset
REQ-028 rst_n=0 at any edge SHALL force IDLE, busy=0, rd_en=0, rd_addr=0, result=0, result_valid=0, accumulator=0, delayed valid=0.
REQ-029 Reset mid-operation SHALL abort with no result_valid pulse; start sampled on the first edge with rst_n=1 SHALL be honoured.

Verification
REQ-030 A=[1,2,3,4], B=[5,6,7,8] at 0..3, start with vec_base=0 -> reads addr 0..3, result=70, result_valid one cycle, 5 cycles after start.
REQ-031 A=[-1,-2,3,0], B=[4,5,-6,9] -> result=-32 (0xFFFFFFE0); A=B=[0x7FFFFFFF x4] -> result wraps to lower 32 bits of sum (0x00000004).
REQ-032 vec_base=30 -> rd_addr sequence 30,31,0,1, result equals dot product of those entries.
REQ-033 start pulsed at cycles 2 and 3 after first start -> ignored, exactly one result_valid; start during result_valid cycle -> second result_valid exactly VEC_LEN+1 cycles later.
REQ-034 rst_n=0 for one cycle during READ -> all outputs 0 next cycle, no result_valid; subsequent start yields correct result.
REQ-035 Chain with downstream writer: two operations -> writer receives result/result_valid pairs in order, memory holds 70 then second value.
